// File: rtl/instr_mem_pkg.sv
// Shared definitions for the instruction-store loader and any memory model that reads it back.
// Byte lanes are big-endian: lane 0 is word bits [31:24].
package instr_mem_pkg;

    localparam int MEM_BYTES_DEF = 64;
    localparam int WORD_W        = 32;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_ACCEPT,
        LD_WRITE,
        LD_DONE,
        LD_OVF
    } ld_state_t;

    function automatic logic [7:0] byte_lane(input logic [WORD_W-1:0] word, input logic [1:0] idx);
        logic [7:0] lane;
        case (idx)
            2'd0:    lane = word[31:24];
            2'd1:    lane = word[23:16];
            2'd2:    lane = word[15:8];
            default: lane = word[7:0];
        endcase
        return lane;
    endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// Word stream into the loader (valid/ready) and the byte write port out of it.
// The write port has no backpressure: the store accepts one byte per cycle.
interface word_stream_if;
    import instr_mem_pkg::*;

    logic              valid;
    logic              ready;
    logic [WORD_W-1:0] word;
    logic              last;

    modport master(output valid, word, last, input ready);
    modport slave(input valid, word, last, output ready);
endinterface

interface byte_wr_if #(parameter int ADDR_W = 6);
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;

    modport master(output we, addr, data);
    modport slave(input we, addr, data);
endinterface

// File: rtl/word_byte_serializer.sv
// Holds the accepted word and steps through its four byte lanes, MSB lane first.
// Output byte is decoded from registers only; load wins over advance.
module word_byte_serializer
    import instr_mem_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              advance,
    input  logic [WORD_W-1:0] word,
    output logic [7:0]        mem_data,
    output logic [1:0]        byte_idx,
    output logic              last_byte
);

    logic [WORD_W-1:0] word_q;
    logic [1:0]        idx_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            word_q <= '0;
            idx_q  <= '0;
        end else if (load) begin
            word_q <= word;
            idx_q  <= '0;
        end else if (advance) begin
            idx_q  <= idx_q + 2'd1;
        end
    end

    assign mem_data  = byte_lane(word_q, idx_q);
    assign byte_idx  = idx_q;
    assign last_byte = (idx_q == 2'd3);

endmodule

// File: rtl/instr_mem_loader.sv
// Loads a program into the byte-addressed instruction store: one word in, four byte writes out.
// First byte write 1 cycle after the handshake; one word per 5 cycles; in_ready low while writing.
module instr_mem_loader
    import instr_mem_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEF,
    parameter int ADDR_W    = $clog2(MEM_BYTES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    word_stream_if.slave      in_stream,
    byte_wr_if.master         mem_port,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W-2:0] word_count
);

    localparam int                WORDS     = MEM_BYTES / 4;
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);
    localparam logic [ADDR_W-2:0] WC_ONE    = (ADDR_W-1)'(1);

    ld_state_t         state;
    logic [ADDR_W-1:0] base;
    logic              last_q;
    logic              ready_q;
    logic              we_q;
    logic              accept;
    logic [1:0]        byte_idx;
    logic              last_byte;
    logic [7:0]        byte_dat;
    logic [ADDR_W-2:0] wc_next;

    assign accept  = (state == LD_ACCEPT) && in_stream.valid;
    assign wc_next = word_count + WC_ONE;

    word_byte_serializer u_ser (
        .clk       (clk),
        .reset     (reset),
        .load      (accept),
        .advance   (state == LD_WRITE),
        .word      (in_stream.word),
        .mem_data  (byte_dat),
        .byte_idx  (byte_idx),
        .last_byte (last_byte)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= LD_IDLE;
            base       <= '0;
            last_q     <= 1'b0;
            ready_q    <= 1'b0;
            we_q       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            word_count <= '0;
        end else begin
            case (state)
                LD_IDLE, LD_DONE, LD_OVF: begin
                    if (start) begin
                        state      <= LD_ACCEPT;
                        ready_q    <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        overflow   <= 1'b0;
                        base       <= '0;
                        word_count <= '0;
                    end
                end
                LD_ACCEPT: begin
                    if (accept) begin
                        state   <= LD_WRITE;
                        ready_q <= 1'b0;
                        we_q    <= 1'b1;
                        last_q  <= in_stream.last;
                    end
                end
                LD_WRITE: begin
                    if (last_byte) begin
                        we_q       <= 1'b0;
                        word_count <= wc_next;
                        base       <= base + ADDR_STEP;
                        // base wraps at power-of-two sizes, so fullness is judged by word count
                        if (last_q) begin
                            state <= LD_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else if (int'(wc_next) == WORDS) begin
                            state    <= LD_OVF;
                            busy     <= 1'b0;
                            overflow <= 1'b1;
                        end else begin
                            state   <= LD_ACCEPT;
                            ready_q <= 1'b1;
                        end
                    end
                end
                default: state <= LD_IDLE;
            endcase
        end
    end

    assign in_stream.ready = ready_q;
    assign mem_port.we     = we_q;
    assign mem_port.addr   = base + ADDR_W'(byte_idx);
    assign mem_port.data   = byte_dat;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomised program loads against a reference that expands each accepted word into
// big-endian bytes at 4*i..4*i+3 with the documented handshake and write timing.
module tb_instr_mem_loader;

    localparam int MB = 64;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          busy;
    logic          done;
    logic          overflow;
    logic [AW-2:0] word_count;

    word_stream_if           s_if ();
    byte_wr_if #(.ADDR_W(AW)) m_if ();

    instr_mem_loader #(.MEM_BYTES(MB), .ADDR_W(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_stream  (s_if),
        .mem_port   (m_if),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          wr_addr_q[$];
    int          wr_data_q[$];
    int          wr_cyc_q[$];
    int          acc_cyc_q[$];
    logic [31:0] words[$];
    logic [7:0]  mem_model[MB];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (m_if.we) begin
            wr_addr_q.push_back(int'(m_if.addr));
            wr_data_q.push_back(int'(m_if.data));
            wr_cyc_q.push_back(cyc);
            mem_model[m_if.addr] = m_if.data;
        end
        if (s_if.valid && s_if.ready) acc_cyc_q.push_back(cyc);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        acc_cyc_q.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic gen_words(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back($urandom);
    endtask

    // Offers words[0..n-1] back to back; with poke, start is pulsed while word 0 is being written.
    task automatic send_words(input int n, input bit last_final, input bit poke);
        int g;
        for (int i = 0; i < n; i++) begin
            s_if.valid = 1'b1;
            s_if.word  = words[i];
            s_if.last  = last_final && (i == n - 1);
            if (poke && i == 1) begin
                start = 1'b1;
                step();
                start = 1'b0;
            end
            g = 0;
            do begin
                @(negedge clk);
                g++;
            end while (!s_if.ready && g < 40);
            if (!s_if.ready) begin
                check($sformatf("accept_w%0d", i), {31'd0, s_if.ready}, 32'd1);
                s_if.valid = 1'b0;
                return;
            end
            step();
        end
        s_if.valid = 1'b0;
        s_if.last  = 1'b0;
    endtask

    task automatic wait_end(output int end_cyc);
        int g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!(done || overflow) && g < 60);
        check("end_seen", {31'd0, done | overflow}, 32'd1);
        end_cyc = cyc;
    endtask

    task automatic check_load(input string tag, input int n, input bit exp_done, input int end_cyc);
        int j;
        check({tag, "_nacc"}, acc_cyc_q.size(), n);
        check({tag, "_nwr"}, wr_addr_q.size(), 4 * n);
        for (int i = 1; i < acc_cyc_q.size(); i++)
            check($sformatf("%s_gap%0d", tag, i), acc_cyc_q[i] - acc_cyc_q[i-1], 5);
        if (wr_addr_q.size() == 4 * n && acc_cyc_q.size() == n && n > 0) begin
            for (j = 0; j < 4 * n; j++) begin
                check($sformatf("%s_addr%0d", tag, j), wr_addr_q[j], j);
                check($sformatf("%s_data%0d", tag, j), wr_data_q[j],
                      (words[j / 4] >> (24 - 8 * (j % 4))) & 32'hFF);
                check($sformatf("%s_cyc%0d", tag, j), wr_cyc_q[j], acc_cyc_q[j / 4] + 1 + j % 4);
            end
            check({tag, "_flag_lat"}, end_cyc, wr_cyc_q[4 * n - 1] + 1);
        end
        check({tag, "_done"}, {31'd0, done}, {31'd0, exp_done});
        check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, !exp_done});
        check({tag, "_wc"}, word_count, n);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int e;
        int g;

        reset      = 1'b1;
        start      = 1'b0;
        s_if.valid = 1'b0;
        s_if.word  = '0;
        s_if.last  = 1'b0;
        repeat (2) step();
        reset = 1'b0;
        clear_log();

        @(negedge clk);
        check("rst_ready", {31'd0, s_if.ready}, 32'd0);
        check("rst_we", {31'd0, m_if.we}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        check("rst_addr", m_if.addr, 0);
        check("rst_data", m_if.data, 0);
        check("rst_wc", word_count, 0);
        step();

        // single known word
        pulse_start();
        @(negedge clk);
        check("start_ready", {31'd0, s_if.ready}, 32'd1);
        check("start_busy", {31'd0, busy}, 32'd1);
        step();
        words.delete();
        words.push_back(32'h8B1F0041);
        send_words(1, 1'b1, 1'b0);
        wait_end(e);
        check_load("one", 1, 1'b1, e);

        // three words, valid held high throughout
        clear_log();
        pulse_start();
        gen_words(3);
        send_words(3, 1'b1, 1'b0);
        wait_end(e);
        check_load("three", 3, 1'b1, e);
        check("readback4", {mem_model[4], mem_model[5], mem_model[6], mem_model[7]}, words[1]);

        // last word lands exactly at the top of the store
        clear_log();
        pulse_start();
        gen_words(16);
        send_words(16, 1'b1, 1'b0);
        wait_end(e);
        check_load("full", 16, 1'b1, e);

        // same length without in_last fills the store
        clear_log();
        pulse_start();
        gen_words(16);
        send_words(16, 1'b0, 1'b0);
        wait_end(e);
        check_load("ovf", 16, 1'b0, e);
        s_if.valid = 1'b1;
        s_if.word  = $urandom;
        repeat (10) @(negedge clk);
        check("ovf_ready", {31'd0, s_if.ready}, 32'd0);
        check("ovf_noacc", acc_cyc_q.size(), 16);
        check("ovf_nowr", wr_addr_q.size(), 64);
        s_if.valid = 1'b0;

        // reset during the second byte of word 3
        clear_log();
        pulse_start();
        @(negedge clk);
        check("ovf_cleared", {31'd0, overflow}, 32'd0);
        step();
        gen_words(3);
        send_words(3, 1'b0, 1'b0);
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!(m_if.we && m_if.addr == 6'd9) && g < 10);
        check("rst_point", m_if.addr, 9);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_we", {31'd0, m_if.we}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_wc", word_count, 0);
        step();
        reset = 1'b0;
        repeat (3) step();
        check("mid_rst_nwr", wr_addr_q.size(), 10);
        clear_log();
        pulse_start();
        gen_words(1);
        send_words(1, 1'b1, 1'b0);
        wait_end(e);
        check_load("reload", 1, 1'b1, e);

        // start pulsed and in_valid held while word 0 is being written
        clear_log();
        pulse_start();
        gen_words(2);
        send_words(2, 1'b1, 1'b1);
        wait_end(e);
        check_load("busy_start", 2, 1'b1, e);

        // restart after done
        clear_log();
        pulse_start();
        @(negedge clk);
        check("re_done", {31'd0, done}, 32'd0);
        check("re_wc", word_count, 0);
        check("re_busy", {31'd0, busy}, 32'd1);
        check("re_ready", {31'd0, s_if.ready}, 32'd1);
        step();
        gen_words(1);
        send_words(1, 1'b1, 1'b0);
        wait_end(e);
        check_load("restart", 1, 1'b1, e);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Write-side companion of the processor's byte-addressed instruction memory. Accepts 32-bit instruction words over a valid/ready stream and serialises each into four big-endian byte writes. The byte at the lowest address is instruction bits [31:24], so a 4-byte read at address A returns the original word. Sits between the program-load source (testbench or boot channel) and the instruction store's byte write port, replacing file-based preload.

## Interface
- MEM_BYTES, 64, instruction store size in bytes; multiple of 4, ≥ 4
- ADDR_W, $clog2(MEM_BYTES), byte address width
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  begin a load at byte address 0; ignored while busy
- in_valid  input  1  in_word/in_last valid
- in_ready  output  1  loader accepts a word this cycle
- in_word  input  32  instruction word
- in_last  input  1  marks final word of program
- mem_we  output  1  byte write strobe
- mem_addr  output  ADDR_W  byte address
- mem_data  output  8  byte to write
- busy  output  1  load in progress
- done  output  1  program loaded; held until next start
- overflow  output  1  non-last word filled the store; held until next start
- word_count  output  ADDR_W-1  words written in current/last load

## Operation
- States: IDLE, ACCEPT, WRITE, DONE, OVF.
- IDLE: in_ready=0, mem_we=0. start → ACCEPT; base address := 0, word_count := 0.
- ACCEPT: in_ready=1. On in_valid&in_ready, latch in_word and in_last, byte_idx := 0, go to WRITE.
- WRITE, 4 cycles:
  - mem_we=1, mem_addr=base+byte_idx, mem_data=word[31-8*byte_idx -: 8].
  - in_ready=0.
  - After byte_idx=3: word_count+1, base+4.
  - Then: latched last → DONE; else new base == MEM_BYTES → OVF; else → ACCEPT.
- DONE: done=1, busy=0. OVF: overflow=1, busy=0. start in either state clears the flag → ACCEPT from address 0.
- busy=1 in ACCEPT and WRITE only.
- start while busy: ignored. in_valid outside ACCEPT: ignored, word not consumed.
- Last word landing exactly at MEM_BYTES-4: DONE, not OVF.
- Address arithmetic is modulo 2^ADDR_W and never exceeds MEM_BYTES-1 when mem_we=1.

## Timing
- Reset values: state IDLE; in_ready, mem_we, busy, done, overflow = 0; mem_addr, mem_data, word_count = 0.
- Reset mid-operation: next cycle IDLE with all outputs at reset values. A partially written word is abandoned; no further mem_we.
- Handshake to first byte write: 1 cycle. Word accepted at edge N; mem_we high in cycles N+1..N+4.
- Throughput: one word per 5 cycles. in_ready reasserts the cycle after the 4th byte write.
- start to in_ready=1: 1 cycle.
- done/overflow assert in the cycle after the final byte write.
- All outputs are registered or decoded from registered state; no combinational path from in_* to mem_*.

## Structure
- Shared package instr_mem_pkg holds:
  - MEM_BYTES default and the word width (32)
  - the loader state enum
  - a byte-lane select function (word, idx) → byte, used by both loader and memory model
- One natural sub-module: word_byte_serializer. It holds the word register and byte_idx counter and produces mem_data/byte_idx/last_byte. The FSM, address and word counting stay in instr_mem_loader.

## Test plan
- Reset, start, one word 0x8B1F0041 with in_last: writes 0x8B@0, 0x1F@1, 0x00@2, 0x41@3 in consecutive cycles; done=1 next cycle; word_count=1.
- Three words with in_valid held high: in_ready pulses every 5 cycles. Bytes land at 0–11. A read-back concatenation at address 4 equals word 2.
- 16 words, last flagged on the 16th (MEM_BYTES=64): final write at address 63; done=1, overflow=0. Same stream without in_last: overflow=1, no write beyond address 63.
- reset asserted during the 2nd byte of word 3: next cycle mem_we=0, busy=0, word_count=0. A new start reloads from address 0.
- start pulsed while busy and in_valid asserted during WRITE: no restart, no extra acceptance, byte sequence unchanged.
- After done, start: done clears, word_count=0, next word writes at address 0.
